// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the 64-row SRAM access path.
//   - state_e           : sequencing controller state encoding
//                         (IDLE=0, PRE=1, WL=2, SENSE=3, RESP=4)
//   - DEFAULT_*_WIDTH   : row address / word widths shared with the row decoder
//   - max_int           : larger of two integers
//   - phase_cnt_width   : width of the phase down-counter for given phase lengths
// ---------------------------------------------------------------------------
package sram_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_WL    = 3'd2,
    ST_SENSE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One extra bit above clog2 so the longest phase length itself is representable.
  function automatic int phase_cnt_width(input int pre_cycles, input int wl_cycles);
    return $clog2(max_int(pre_cycles, wl_cycles)) + 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Loadable down-counter timing the precharge and wordline phases.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset (count -> 0)
//   load        in   load strobe, has priority over counting
//   load_value  in   CNT_WIDTH value loaded on load
//   done        out  high while count == 1 (last cycle of the phase)
// ---------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(1'b0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

  logic [CNT_WIDTH-1:0] count_r;

  // Count register: load wins, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != CNT_ZERO) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == CNT_ONE);

endmodule

// File: rtl/sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_access_ctrl
// Sequencing controller for the 64-row SRAM macro. Takes one read or write
// request at a time and walks the array through precharge, wordline,
// (sense for reads) and response phases in a fixed non-overlapping order.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE, not in reset)
//   req_we/addr/wdata        request fields, latched on acceptance
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata                last word read, held until the next read's SENSE
//   dec_addr/dec_enable      row decoder address and enable
//   pre_en                   bitline precharge enable
//   wr_en/wr_data            bitline write drivers
//   sae/sense_data           sense-amp enable and sense-amp outputs
// ---------------------------------------------------------------------------
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PRE_CYCLES = 2,
  parameter int WL_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] dec_addr,
  output logic                  dec_enable,
  output logic                  pre_en,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  sae,
  input  logic [DATA_WIDTH-1:0] sense_data
);

  localparam int CNT_WIDTH = phase_cnt_width(PRE_CYCLES, WL_CYCLES);
  localparam logic [CNT_WIDTH-1:0] PRE_LOAD = CNT_WIDTH'(PRE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] WL_LOAD  = CNT_WIDTH'(WL_CYCLES);

  state_e                state_r;
  state_e                state_nxt_s;
  logic                  accept_s;
  logic                  timer_load_s;
  logic [CNT_WIDTH-1:0]  timer_value_s;
  logic                  timer_done_s;

  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic                  pre_en_r;
  logic                  dec_enable_r;
  logic                  wr_en_r;
  logic                  sae_r;
  logic                  rsp_valid_r;

  logic                  pre_en_nxt_s;
  logic                  dec_enable_nxt_s;
  logic                  wr_en_nxt_s;
  logic                  sae_nxt_s;
  logic                  rsp_valid_nxt_s;

  // Ready is the only output that sees rst combinationally, so a request
  // presented together with reset is never handshaken.
  assign req_ready = (state_r == ST_IDLE) & ~rst;
  assign accept_s  = req_valid & req_ready;

  phase_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .done       (timer_done_s)
  );

  // Next-state logic; the timer is reloaded on entry to each timed phase.
  always_comb begin
    state_nxt_s   = state_r;
    timer_load_s  = 1'b0;
    timer_value_s = PRE_LOAD;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s   = ST_PRE;
          timer_load_s  = 1'b1;
          timer_value_s = PRE_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (timer_done_s) begin
          state_nxt_s   = ST_WL;
          timer_load_s  = 1'b1;
          timer_value_s = WL_LOAD;
        end else begin
          state_nxt_s = ST_PRE;
        end
      end
      ST_WL: begin
        if (timer_done_s) begin
          if (we_r) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_SENSE;
          end
        end else begin
          state_nxt_s = ST_WL;
        end
      end
      ST_SENSE: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Array-control decode of the upcoming state; registered below so the
  // outputs are glitch-free and exactly aligned with the state they describe.
  always_comb begin
    pre_en_nxt_s     = 1'b0;
    dec_enable_nxt_s = 1'b0;
    wr_en_nxt_s      = 1'b0;
    sae_nxt_s        = 1'b0;
    rsp_valid_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        pre_en_nxt_s = 1'b0;
      end
      ST_PRE: begin
        pre_en_nxt_s = 1'b1;
      end
      ST_WL: begin
        // we_r is already stable here: it only changes on acceptance in IDLE.
        dec_enable_nxt_s = 1'b1;
        wr_en_nxt_s      = we_r;
      end
      ST_SENSE: begin
        dec_enable_nxt_s = 1'b1;
        sae_nxt_s        = 1'b1;
      end
      ST_RESP: begin
        rsp_valid_nxt_s = 1'b1;
      end
      default: begin
        pre_en_nxt_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latches: captured only on acceptance, held through the access and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      we_r    <= req_we;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Registered array controls and response pulse; reset forces all low next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_en_r     <= 1'b0;
      dec_enable_r <= 1'b0;
      wr_en_r      <= 1'b0;
      sae_r        <= 1'b0;
      rsp_valid_r  <= 1'b0;
    end else begin
      pre_en_r     <= pre_en_nxt_s;
      dec_enable_r <= dec_enable_nxt_s;
      wr_en_r      <= wr_en_nxt_s;
      sae_r        <= sae_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
    end
  end

  // Read data capture at the end of SENSE; writes leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (state_r == ST_SENSE) begin
      rdata_r <= sense_data;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign pre_en     = pre_en_r;
  assign dec_enable = dec_enable_r;
  assign wr_en      = wr_en_r;
  assign sae        = sae_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rdata_r;
  assign dec_addr   = addr_r;
  assign wr_data    = wdata_r;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_access_ctrl
// Two controllers: instance 0 with default phase lengths (2/2), instance 1
// with PRE_CYCLES=1, WL_CYCLES=3. A reference model tracks each access as a
// cycle offset k from acceptance and derives every expected output from the
// phase-length arithmetic. Directed scenarios run on instance 0, then both
// instances receive random traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_sram_access_ctrl;

  localparam int AW     = 6;
  localparam int DW     = 8;
  localparam int PRE_A  = 2;
  localparam int WL_A   = 2;
  localparam int PRE_B  = 1;
  localparam int WL_B   = 3;
  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_v        [2];
  logic          req_valid_v  [2];
  logic          req_ready_v  [2];
  logic          req_we_v     [2];
  logic [AW-1:0] req_addr_v   [2];
  logic [DW-1:0] req_wdata_v  [2];
  logic          rsp_valid_v  [2];
  logic [DW-1:0] rsp_rdata_v  [2];
  logic [AW-1:0] dec_addr_v   [2];
  logic          dec_enable_v [2];
  logic          pre_en_v     [2];
  logic          wr_en_v      [2];
  logic [DW-1:0] wr_data_v    [2];
  logic          sae_v        [2];
  logic [DW-1:0] sense_data_v [2];

  sram_access_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRE_CYCLES(PRE_A), .WL_CYCLES(WL_A)
  ) dut_a (
    .clk(clk), .rst(rst_v[0]), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_we(req_we_v[0]), .req_addr(req_addr_v[0]), .req_wdata(req_wdata_v[0]),
    .rsp_valid(rsp_valid_v[0]), .rsp_rdata(rsp_rdata_v[0]), .dec_addr(dec_addr_v[0]),
    .dec_enable(dec_enable_v[0]), .pre_en(pre_en_v[0]), .wr_en(wr_en_v[0]),
    .wr_data(wr_data_v[0]), .sae(sae_v[0]), .sense_data(sense_data_v[0])
  );

  sram_access_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRE_CYCLES(PRE_B), .WL_CYCLES(WL_B)
  ) dut_b (
    .clk(clk), .rst(rst_v[1]), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_we(req_we_v[1]), .req_addr(req_addr_v[1]), .req_wdata(req_wdata_v[1]),
    .rsp_valid(rsp_valid_v[1]), .rsp_rdata(rsp_rdata_v[1]), .dec_addr(dec_addr_v[1]),
    .dec_enable(dec_enable_v[1]), .pre_en(pre_en_v[1]), .wr_en(wr_en_v[1]),
    .wr_data(wr_data_v[1]), .sae(sae_v[1]), .sense_data(sense_data_v[1])
  );

  // Reference model state per instance.
  int            pre_n [2] = '{PRE_A, PRE_B};
  int            wl_n  [2] = '{WL_A, WL_B};
  bit            busy     [2];
  int            k        [2];
  bit            m_we     [2];
  logic [AW-1:0] m_addr   [2];
  logic [DW-1:0] m_wdata  [2];
  logic [DW-1:0] m_rdata  [2];
  int            acc_cyc  [2];
  int            n_req    [2];
  bit            accepted [2];

  int cyc        = 0;
  int test_count = 0;
  int fail_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs(input int i);
    int last;
    bit e_pre, e_dec, e_wr, e_sae, e_rsp;
    last  = m_we[i] ? (pre_n[i] + wl_n[i] + 1) : (pre_n[i] + wl_n[i] + 2);
    e_pre = busy[i] && (k[i] <= pre_n[i]);
    e_wr  = busy[i] && m_we[i] && (k[i] > pre_n[i]) && (k[i] <= pre_n[i] + wl_n[i]);
    e_sae = busy[i] && !m_we[i] && (k[i] == pre_n[i] + wl_n[i] + 1);
    e_dec = (busy[i] && (k[i] > pre_n[i]) && (k[i] <= pre_n[i] + wl_n[i])) || e_sae;
    e_rsp = busy[i] && (k[i] == last);
    check_eq($sformatf("pre_en[%0d]", i),     32'(pre_en_v[i]),     32'(e_pre));
    check_eq($sformatf("dec_enable[%0d]", i), 32'(dec_enable_v[i]), 32'(e_dec));
    check_eq($sformatf("wr_en[%0d]", i),      32'(wr_en_v[i]),      32'(e_wr));
    check_eq($sformatf("sae[%0d]", i),        32'(sae_v[i]),        32'(e_sae));
    check_eq($sformatf("rsp_valid[%0d]", i),  32'(rsp_valid_v[i]),  32'(e_rsp));
    check_eq($sformatf("dec_addr[%0d]", i),   32'(dec_addr_v[i]),   32'(m_addr[i]));
    check_eq($sformatf("wr_data[%0d]", i),    32'(wr_data_v[i]),    32'(m_wdata[i]));
    check_eq($sformatf("rsp_rdata[%0d]", i),  32'(rsp_rdata_v[i]),  32'(m_rdata[i]));
    check_eq($sformatf("inv_pre_dec[%0d]", i), 32'(pre_en_v[i] & dec_enable_v[i]), 32'd0);
    check_eq($sformatf("inv_wr_sae[%0d]", i),  32'(wr_en_v[i] & sae_v[i]), 32'd0);
    check_eq($sformatf("inv_nest[%0d]", i),    32'((wr_en_v[i] | sae_v[i]) & ~dec_enable_v[i]), 32'd0);
    if (rsp_valid_v[i]) begin
      check_eq($sformatf("latency[%0d]", i), 32'(cyc - acc_cyc[i]),
               32'(m_we[i] ? (1 + pre_n[i] + wl_n[i]) : (2 + pre_n[i] + wl_n[i])));
    end
  endtask

  // Advance the model across the coming edge, using the inputs now applied.
  task automatic model_update(input int i);
    int last;
    last = m_we[i] ? (pre_n[i] + wl_n[i] + 1) : (pre_n[i] + wl_n[i] + 2);
    if (rst_v[i]) begin
      busy[i]    = 1'b0;
      k[i]       = 0;
      m_addr[i]  = '0;
      m_wdata[i] = '0;
      m_rdata[i] = '0;
    end else if (busy[i]) begin
      if (!m_we[i] && (k[i] == pre_n[i] + wl_n[i] + 1)) m_rdata[i] = sense_data_v[i];
      if (k[i] == last) busy[i] = 1'b0;
      else k[i] = k[i] + 1;
    end else if (req_valid_v[i]) begin
      busy[i]     = 1'b1;
      k[i]        = 1;
      m_we[i]     = req_we_v[i];
      m_addr[i]   = req_addr_v[i];
      m_wdata[i]  = req_wdata_v[i];
      acc_cyc[i]  = cyc;
      n_req[i]    = n_req[i] + 1;
      accepted[i] = 1'b1;
    end
  endtask

  task automatic step();
    #1;
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("req_ready[%0d]", i), 32'(req_ready_v[i]), 32'(!busy[i] && !rst_v[i]));
    for (int i = 0; i < 2; i++) model_update(i);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_valid_v[i] = 1'b1;
    req_we_v[i]    = we;
    req_addr_v[i]  = addr;
    req_wdata_v[i] = wdata;
  endtask

  task automatic drive_random(input int i);
    if (accepted[i]) begin
      req_valid_v[i] = 1'b0;
      accepted[i]    = 1'b0;
    end
    if (!req_valid_v[i] && ($urandom_range(0, 3) != 0))
      set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    rst_v[i]        = ($urandom_range(0, 199) == 0);
    sense_data_v[i] = DW'($urandom);
  endtask

  initial begin
    bit rsp_seen;
    int guard;
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; req_valid_v[i] = 1'b0; req_we_v[i] = 1'b0;
      req_addr_v[i] = '0; req_wdata_v[i] = '0; sense_data_v[i] = '0;
    end
    step();
    step();
    check_eq("reset_ready_low", 32'(req_ready_v[0]), 32'd0);
    check_eq("reset_rdata",     32'(rsp_rdata_v[0]), 32'd0);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // Write 0x2A <- 0xC3
    set_req(0, 1'b1, 6'h2A, 8'hC3);
    for (int n = 1; n <= 6; n++) begin
      step();
      if (n == 1) req_valid_v[0] = 1'b0;
      check_eq("wr_pre",  32'(pre_en_v[0]),     32'(n <= 2));
      check_eq("wr_dec",  32'(dec_enable_v[0]), 32'(n == 3 || n == 4));
      check_eq("wr_wren", 32'(wr_en_v[0]),      32'(n == 3 || n == 4));
      check_eq("wr_rsp",  32'(rsp_valid_v[0]),  32'(n == 5));
      if (n == 3 || n == 4) begin
        check_eq("wr_addr", 32'(dec_addr_v[0]), 32'h2A);
        check_eq("wr_data", 32'(wr_data_v[0]),  32'hC3);
      end
      if (n == 5) check_eq("wr_rdata_kept", 32'(rsp_rdata_v[0]), 32'd0);
    end

    // Read 0x3F, sense amps return 0x5A
    sense_data_v[0] = 8'h5A;
    set_req(0, 1'b0, 6'h3F, 8'h00);
    for (int n = 1; n <= 7; n++) begin
      step();
      if (n == 1) req_valid_v[0] = 1'b0;
      check_eq("rd_sae",  32'(sae_v[0]),       32'(n == 5));
      check_eq("rd_rsp",  32'(rsp_valid_v[0]), 32'(n == 6));
      check_eq("rd_wren", 32'(wr_en_v[0]),     32'd0);
      if (n == 6) check_eq("rd_rdata", 32'(rsp_rdata_v[0]), 32'h5A);
    end

    // A following write leaves the read data alone.
    sense_data_v[0] = 8'h00;
    set_req(0, 1'b1, 6'h01, 8'h77);
    for (int n = 1; n <= 6; n++) begin
      step();
      if (n == 1) req_valid_v[0] = 1'b0;
    end
    check_eq("rdata_after_write", 32'(rsp_rdata_v[0]), 32'h5A);

    // Back-to-back with req_valid held high.
    set_req(0, 1'b1, 6'h10, 8'hA5);
    step();
    set_req(0, 1'b0, 6'h11, 8'h00);
    rsp_seen = 1'b0;
    for (int n = 0; n < 20 && !rsp_seen; n++) begin
      check_eq("b2b_ready_low", 32'(req_ready_v[0]), 32'd0);
      step();
      rsp_seen = rsp_valid_v[0];
    end
    check_eq("b2b_first_rsp", 32'(rsp_seen), 32'd1);
    step();
    check_eq("b2b_ready_after_rsp", 32'(req_ready_v[0]), 32'd1);
    step();
    req_valid_v[0] = 1'b0;
    check_eq("b2b_second_pre", 32'(pre_en_v[0]), 32'd1);
    for (int n = 0; n < 8; n++) step();

    // Reset during the wordline phase of a read.
    sense_data_v[0] = 8'hE7;
    set_req(0, 1'b0, 6'h05, 8'h00);
    for (int n = 1; n <= 3; n++) begin
      step();
      if (n == 1) req_valid_v[0] = 1'b0;
    end
    check_eq("rstwl_in_wl", 32'(dec_enable_v[0]), 32'd1);
    rst_v[0] = 1'b1;
    set_req(0, 1'b1, 6'h22, 8'h99);
    step();
    check_eq("rstwl_ctrl", 32'({pre_en_v[0], dec_enable_v[0], wr_en_v[0], sae_v[0]}), 32'd0);
    check_eq("rstwl_rsp",   32'(rsp_valid_v[0]), 32'd0);
    check_eq("rstwl_rdata", 32'(rsp_rdata_v[0]), 32'd0);
    step();
    check_eq("rst_wins", 32'(pre_en_v[0]), 32'd0);
    rst_v[0] = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(req_ready_v[0]), 32'd1);
    step();
    req_valid_v[0] = 1'b0;
    check_eq("post_rst_accept", 32'(pre_en_v[0]), 32'd1);
    for (int n = 0; n < 8; n++) step();

    // Random traffic on both instances.
    n_req[0] = 0;
    n_req[1] = 0;
    guard    = 0;
    while ((n_req[0] < N_RAND || n_req[1] < N_RAND) && guard < 40000) begin
      for (int i = 0; i < 2; i++) drive_random(i);
      step();
      guard++;
    end
    check_eq("rand_reqs_a", 32'(n_req[0] >= N_RAND), 32'd1);
    check_eq("rand_reqs_b", 32'(n_req[1] >= N_RAND), 32'd1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
